// File: rtl/mealy_det_pkg.sv
// Shared types for the 1011 serial pattern detector.
package mealy_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_1    = 2'd1,
        S_10   = 2'd2,
        S_101  = 2'd3
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/mealy_seq_det_1011.sv
// Overlapping 1011 detector, Mealy FSM. Define MEALY_DET_REG_OUT_EN to register
// the detect flag (one cycle later); otherwise out is combinational from in.
module mealy_seq_det_1011
    import mealy_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    state_t state_q, state_d;
    logic   det;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Detections fall back to the longest suffix that is still a prefix of 1011.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = in ? S_1   : S_IDLE;
            S_1:     state_d = in ? S_1   : S_10;
            S_10:    state_d = in ? S_101 : S_IDLE;
            S_101:   state_d = in ? S_1   : S_10;
            default: state_d = S_IDLE;
        endcase
    end

    assign det = (state_q == S_101) && in;

`ifdef MEALY_DET_REG_OUT_EN
    logic out_q;

    always_ff @(posedge clk) begin
        if (rst) out_q <= 1'b0;
        else     out_q <= det;
    end

    always_comb begin
        out = out_q;
    end
`else
    always_comb begin
        out = det && !rst;
    end
`endif

endmodule

// File: tb/tb_mealy_seq_det_1011.sv
// Directed-vector bench for mealy_seq_det_1011 with a bit-history reference model.
module tb_mealy_seq_det_1011;
    import mealy_det_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in  = 1'b0;
    logic out;

    int   errors = 0;
    int   checks = 0;
    logic chk_en = 1'b0;
    logic exp_out = 1'b0;
    logic last_det = 1'b0;
    bit   hist[$];

    mealy_seq_det_1011 dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out)
    );

    always #5 clk = ~clk;

    // Model: a detect happens when the bits seen since the last reset end in
    // the first three bits of PATTERN and the current bit is its last bit.
    function automatic logic model_det(input logic r, input logic b);
        logic [3:0] p;
        int n;
        p = PATTERN;
        n = hist.size();
        if (r || n < 3) return 1'b0;
        return (hist[n-3] == p[3]) && (hist[n-2] == p[2]) &&
               (hist[n-1] == p[1]) && (b == p[0]);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (out !== exp_out) begin
                errors++;
                $display("FAIL model_cmp t=%0t rst=%0b in=%0b out=%0b expected=%0b",
                         $time, rst, in, out, exp_out);
            end
        end
    end

    task automatic apply(input logic r, input logic b, input logic en);
        logic d;
        @(posedge clk);
        #1;
        rst = r;
        in  = b;
        d = model_det(r, b);
`ifdef MEALY_DET_REG_OUT_EN
        exp_out  = last_det;
        last_det = d;
`else
        exp_out = d;
`endif
        if (r) hist.delete();
        else begin
            hist.push_back(b);
            if (hist.size() > 3) void'(hist.pop_front());
        end
        chk_en = en;
    endtask

    // Each sequence is preceded by one reset cycle; lit holds the hand-computed
    // combinational detect per bit, which the registered build sees one cycle later.
    task automatic run_seq(input string name, input string bits,
                           input string rsts, input string lit);
        logic lit_now, lit_prev, d;
        apply(1'b1, 1'b0, 1'b1);
        lit_prev = 1'b0;
        for (int i = 0; i < bits.len(); i++) begin
            lit_now = (lit[i] == "1");
            d = model_det(rsts[i] == "1", bits[i] == "1");
            checks++;
            if (d !== lit_now) begin
                errors++;
                $display("FAIL %s model_pin bit%0d model=%0b expected=%0b", name, i, d, lit_now);
            end
            apply(rsts[i] == "1", bits[i] == "1", 1'b1);
            @(negedge clk);
            #1;
            checks++;
`ifdef MEALY_DET_REG_OUT_EN
            if (out !== lit_prev) begin
                errors++;
                $display("FAIL %s bit%0d out=%0b expected=%0b", name, i, out, lit_prev);
            end
`else
            if (out !== lit_now) begin
                errors++;
                $display("FAIL %s bit%0d out=%0b expected=%0b", name, i, out, lit_now);
            end
`endif
            lit_prev = lit_now;
        end
    endtask

    initial begin
        // Power-up reset: out is only meaningful once a reset edge has been seen.
        apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b1);
        apply(1'b0, 1'b0, 1'b1);

        run_seq("basic",     "10110",         "00000",         "00010");
        run_seq("overlap",   "101101110110",  "000000000000",  "000100100010");
        run_seq("near_miss", "1010110",       "0000000",       "0000010");
        run_seq("mid_reset", "101101110110",  "000100000000",  "000000000010");
        run_seq("rst_gate",  "101101110110",  "000100000000",  "000000000010");
        run_seq("rst_s101",  "101101110110",  "000100000000",  "000000000010");
        run_seq("rst_in1",   "1011011",       "0001000",       "0000000");
        run_seq("non_match", "1111000010110", "0000000000000", "0000000000010");
        run_seq("double",    "10110110",      "00000000",      "00010010");

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
